os_seq_ctrl: RTL and testbench

Hardware sequencer for the output-stationary core. It replaces the host-driven instruction stream with a registered FSM that issues the 38-bit `inst` word plus the side controls `hold_cq` and `mac_deliver`. Per input channel it runs L0 fill, north-IFIFO fill, execute, drain and array clear. After the last channel it runs c_q delivery, OFIFO-to-pmem writeback and accumulate/ReLU readout. It sits between the host/memory loader and `core`.

---
 rtl/os_ctrl_pkg.sv | 40 ++++
 rtl/phase_cnt.sv | 28 ++
 rtl/os_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_os_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/os_ctrl_pkg.sv
// Shared definitions for the output-stationary sequencer: state encoding,
// core instruction field positions and the idle instruction word.
package os_ctrl_pkg;

  localparam int INST_W = 38;
  localparam int ADDR_W = 11;

  localparam int B_ACT      = 36;  // two bits: [37:36]
  localparam int B_IFN_RD   = 35;
  localparam int B_IFN_WR   = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_PMEM = 32;
  localparam int B_WEN_PMEM = 31;
  localparam int B_A_PMEM   = 20;  // eleven bits: [30:20]
  localparam int B_CEN_XMEM = 19;
  localparam int B_WEN_XMEM = 18;
  localparam int B_A_XMEM   = 7;   // eleven bits: [17:7]
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXECUTE  = 1;
  localparam int B_LOAD     = 0;

  // Both memories deselected and write-disabled; every other field zero.
  localparam logic [INST_W-1:0] INST_IDLE =
    (INST_W'(1) << B_CEN_PMEM) | (INST_W'(1) << B_WEN_PMEM) |
    (INST_W'(1) << B_CEN_XMEM) | (INST_W'(1) << B_WEN_XMEM);

  typedef enum logic [4:0] {
    S_IDLE, S_WAIT_CH, S_L0, S_GAP1, S_IFN, S_GAP2, S_EXEC, S_DRAIN, S_CLR,
    S_DELIVER, S_GAP3, S_WB, S_ACC_RD, S_ACC_AC, S_ACC_RL, S_ACC_OV, S_DONE
  } os_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Down-counter for phase lengths: loads on state entry, counts to zero and
// holds there; the next value is exported so outputs can be registered early.
module phase_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         zero
);

  always_comb begin
    count_nxt = count;
    if (load)                count_nxt = load_val;
    else if (count != '0)    count_nxt = count - W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_nxt;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/os_seq_ctrl.sv
// Layer sequencer for the output-stationary core: per-channel fill/execute/
// drain/clear, then delivery, pmem writeback and accumulate/ReLU readout.
module os_seq_ctrl
  import os_ctrl_pkg::*;
#(
  parameter int              len_kij   = 9,
  parameter int              len_in_ch = 3,
  parameter int              row       = 8,
  parameter int              gap_cyc   = 10,
  parameter int              drain_cyc = 30,
  parameter logic [ADDR_W-1:0] act_base = 11'h400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ch_ready,
  output logic [INST_W-1:0] inst,
  output logic              hold_cq,
  output logic              mac_deliver,
  output logic              core_clr,
  output logic              ch_req,
  output logic [1:0]        ch_idx,
  output logic              out_valid,
  output logic [2:0]        out_idx,
  output logic              busy,
  output logic              done,
  output os_state_e         dbg_state
);

  localparam int CNT_MAX = max_int(max_int(drain_cyc, gap_cyc), max_int(1 + len_kij, 1 + row));
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  os_state_e         state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [2:0]        row_q, row_d;
  logic              cnt_load, cnt_zero;
  logic [CW-1:0]     cnt_val, cnt, cnt_nxt;
  logic [INST_W-1:0] inst_d;
  logic              hold_d, deliver_d, clr_d, req_d, ov_d, busy_d, done_d;
  logic [2:0]        oidx_d;

  phase_cnt #(.W(CW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_val  (cnt_val),
    .count     (cnt),
    .count_nxt (cnt_nxt),
    .zero      (cnt_zero)
  );

  // State register; outputs are registered from next-state values so each
  // state's controls appear on the edge that enters it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      row_q       <= '0;
      inst        <= INST_IDLE;
      hold_cq     <= 1'b0;
      mac_deliver <= 1'b0;
      core_clr    <= 1'b0;
      ch_req      <= 1'b0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      row_q       <= row_d;
      inst        <= inst_d;
      hold_cq     <= hold_d;
      mac_deliver <= deliver_d;
      core_clr    <= clr_d;
      ch_req      <= req_d;
      out_valid   <= ov_d;
      out_idx     <= oidx_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next-state logic, including channel and readout-row bookkeeping.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    row_d   = row_q;
    unique case (state_q)
      S_IDLE:    if (start) begin state_d = S_WAIT_CH; ch_d = '0; end
      S_WAIT_CH: if (ch_ready) state_d = S_L0;
      S_L0:      if (cnt_zero) state_d = S_GAP1;
      S_GAP1:    if (cnt_zero) state_d = S_IFN;
      S_IFN:     if (cnt_zero) state_d = S_GAP2;
      S_GAP2:    if (cnt_zero) state_d = S_EXEC;
      S_EXEC:    if (cnt_zero) state_d = S_DRAIN;
      S_DRAIN:   if (cnt_zero) state_d = S_CLR;
      S_CLR: begin
        if (ch_q < 2'(len_in_ch - 1)) begin
          ch_d    = ch_q + 2'd1;
          state_d = S_WAIT_CH;
        end else begin
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: if (cnt_zero) state_d = S_GAP3;
      S_GAP3:    if (cnt_zero) state_d = S_WB;
      S_WB:      if (cnt_zero) begin state_d = S_ACC_RD; row_d = '0; end
      S_ACC_RD:  state_d = S_ACC_AC;
      S_ACC_AC:  state_d = S_ACC_RL;
      S_ACC_RL:  state_d = S_ACC_OV;
      S_ACC_OV: begin
        if (row_q == 3'(row - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = S_ACC_RD;
        end
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Phase length minus one is loaded on every state change.
  always_comb begin
    cnt_load = (state_d != state_q);
    cnt_val  = '0;
    case (state_d)
      S_L0, S_IFN:            cnt_val = CW'(len_kij - 1);
      S_GAP1, S_GAP2, S_GAP3: cnt_val = CW'(gap_cyc - 1);
      S_EXEC:                 cnt_val = CW'(len_kij);
      S_DRAIN:                cnt_val = CW'(drain_cyc - 1);
      S_DELIVER:              cnt_val = CW'(row - 1);
      S_WB:                   cnt_val = CW'(row);
      default:                cnt_val = '0;
    endcase
  end

  // Output decode from the upcoming state and counter value.
  always_comb begin
    inst_d    = INST_IDLE;
    hold_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    deliver_d = (state_d == S_DELIVER);
    clr_d     = (state_d == S_CLR);
    req_d     = (state_d == S_WAIT_CH);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    ov_d      = 1'b0;
    oidx_d    = '0;
    case (state_d)
      S_L0: begin
        inst_d[B_CEN_XMEM]          = 1'b0;
        inst_d[B_L0_WR]             = 1'b1;
        inst_d[B_A_XMEM +: ADDR_W]  = act_base + ADDR_W'(len_kij - 1) - ADDR_W'(cnt_nxt);
      end
      S_IFN: begin
        inst_d[B_CEN_XMEM]          = 1'b0;
        inst_d[B_IFN_WR]            = 1'b1;
        inst_d[B_A_XMEM +: ADDR_W]  = ADDR_W'(len_kij - 1) - ADDR_W'(cnt_nxt);
      end
      S_EXEC: begin
        // Reads lead execute by one cycle and drop on the final execute cycle.
        inst_d[B_L0_RD]   = (cnt_nxt != '0);
        inst_d[B_IFN_RD]  = (cnt_nxt != '0);
        inst_d[B_EXECUTE] = (cnt_nxt != CW'(len_kij));
      end
      S_WB: begin
        inst_d[B_OFIFO_RD] = 1'b1;
        if (cnt_nxt != CW'(row)) begin
          inst_d[B_CEN_PMEM]         = 1'b0;
          inst_d[B_WEN_PMEM]         = 1'b0;
          inst_d[B_A_PMEM +: ADDR_W] = ADDR_W'(row - 1) - ADDR_W'(cnt_nxt);
        end
      end
      S_ACC_RD: begin
        inst_d[B_CEN_PMEM]         = 1'b0;
        inst_d[B_A_PMEM +: ADDR_W] = ADDR_W'(row_d);
      end
      S_ACC_AC: inst_d[B_ACC] = 1'b1;
      S_ACC_RL: inst_d[B_ACT +: 2] = 2'b01;
      S_ACC_OV: begin
        ov_d   = 1'b1;
        oidx_d = row_d;
      end
      default: ;
    endcase
    inst_d[B_IFIFO_WR] = 1'b0;
    inst_d[B_IFIFO_RD] = 1'b0;
    inst_d[B_LOAD]     = 1'b0;
  end

  assign ch_idx    = ch_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_os_seq_ctrl.sv
// Directed bench for os_seq_ctrl with default parameters: full layer,
// handshake stall, reset during execute and start ignored while busy.
module tb_os_seq_ctrl;
  import os_ctrl_pkg::*;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset, start, ch_ready;
  logic [37:0] inst;
  logic        hold_cq, mac_deliver, core_clr, ch_req, out_valid, busy, done;
  logic [1:0]  ch_idx;
  logic [2:0]  out_idx;
  os_state_e   dbg_state;

  always #5 clk = ~clk;

  os_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ch_ready    (ch_ready),
    .inst        (inst),
    .hold_cq     (hold_cq),
    .mac_deliver (mac_deliver),
    .core_clr    (core_clr),
    .ch_req      (ch_req),
    .ch_idx      (ch_idx),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard
  logic [12:0] exp_l0[$];
  logic [12:0] exp_ifn[$];
  logic [11:0] exp_wb[$];
  logic [10:0] exp_rd[$];
  logic [3:0]  exp_ov[$];
  int clr_cnt, clr_first, del_cnt, ofifo_cnt, acc_cnt, relu_cnt;
  int rd_cnt, exe_cnt, both_cnt, first_rd, first_exe, pair_bad, never_bad, done_cnt;
  logic hold_at_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_tally();
    logic [10:0] a;
    clr_cnt = 0; clr_first = -1; del_cnt = 0; ofifo_cnt = 0; acc_cnt = 0; relu_cnt = 0;
    rd_cnt = 0; exe_cnt = 0; both_cnt = 0; first_rd = -1; first_exe = -1;
    pair_bad = 0; never_bad = 0; done_cnt = 0; hold_at_done = 1'bx;
    exp_l0.delete(); exp_ifn.delete(); exp_wb.delete(); exp_rd.delete(); exp_ov.delete();
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 9; j++) begin
        a = 11'(1024 + j);
        exp_l0.push_back({1'b0, 1'b1, a});
        a = 11'(j);
        exp_ifn.push_back({1'b0, 1'b1, a});
      end
    end
    for (int i = 0; i < 8; i++) begin
      a = 11'(i);
      exp_wb.push_back({1'b1, a});
      exp_rd.push_back(a);
      exp_ov.push_back(4'(i));
    end
  endtask

  task automatic sample(input int n);
    if (core_clr) begin if (clr_cnt == 0) clr_first = n; clr_cnt++; end
    if (mac_deliver) del_cnt++;
    if (inst[B_OFIFO_RD]) ofifo_cnt++;
    if (inst[B_ACC]) acc_cnt++;
    if (inst[B_ACT +: 2] == 2'b01) relu_cnt++;
    if (inst[B_L0_RD]) begin if (rd_cnt == 0) first_rd = n; rd_cnt++; end
    if (inst[B_EXECUTE]) begin
      if (exe_cnt == 0) first_exe = n;
      exe_cnt++;
      if (inst[B_L0_RD]) both_cnt++;
    end
    if (inst[B_L0_RD] != inst[B_IFN_RD]) pair_bad++;
    if (inst[B_IFIFO_WR] | inst[B_IFIFO_RD] | inst[B_LOAD]) never_bad++;
    if (done) begin done_cnt++; hold_at_done = hold_cq; end
    if (inst[B_L0_WR])
      check("l0_fill", {inst[B_CEN_XMEM], inst[B_WEN_XMEM], inst[B_A_XMEM +: 11]},
            exp_l0.size() != 0 ? exp_l0.pop_front() : 13'h1fff);
    if (inst[B_IFN_WR])
      check("ifn_fill", {inst[B_CEN_XMEM], inst[B_WEN_XMEM], inst[B_A_XMEM +: 11]},
            exp_ifn.size() != 0 ? exp_ifn.pop_front() : 13'h1fff);
    if (!inst[B_CEN_PMEM] && !inst[B_WEN_PMEM])
      check("pmem_wr", {inst[B_OFIFO_RD], inst[B_A_PMEM +: 11]},
            exp_wb.size() != 0 ? exp_wb.pop_front() : 12'hfff);
    if (!inst[B_CEN_PMEM] && inst[B_WEN_PMEM])
      check("pmem_rd", inst[B_A_PMEM +: 11], exp_rd.size() != 0 ? exp_rd.pop_front() : 11'h7ff);
    if (out_valid)
      check("out_idx", {1'b0, out_idx}, exp_ov.size() != 0 ? exp_ov.pop_front() : 4'hf);
  endtask

  task automatic run_to_done(input int n0, output int dn);
    dn = -1;
    for (int n = n0; n < n0 + 1000; n++) begin
      sample(n);
      if (done) begin dn = n; break; end
      @(negedge clk);
    end
    check("done_seen", 64'(dn >= 0), 64'd1);
  endtask

  task automatic verify_layer(input int dn, input int exp_done);
    check("done_cycle", 64'(dn), 64'(exp_done));
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("hold_at_done", 64'(hold_at_done), 64'd0);
    check("clr_pulses", 64'(clr_cnt), 64'd3);
    check("clr_first", 64'(clr_first), 64'd79);
    check("deliver_cyc", 64'(del_cnt), 64'd8);
    check("ofifo_rd_cyc", 64'(ofifo_cnt), 64'd9);
    check("acc_cyc", 64'(acc_cnt), 64'd8);
    check("relu_cyc", 64'(relu_cnt), 64'd8);
    check("rd_cyc", 64'(rd_cnt), 64'd27);
    check("exe_cyc", 64'(exe_cnt), 64'd27);
    check("rd_exe_overlap", 64'(both_cnt), 64'd24);
    check("first_rd", 64'(first_rd), 64'd39);
    check("first_exe", 64'(first_exe), 64'd40);
    check("rd_pair", 64'(pair_bad), 64'd0);
    check("ififo_load_zero", 64'(never_bad), 64'd0);
    check("left_l0", 64'(exp_l0.size()), 64'd0);
    check("left_ifn", 64'(exp_ifn.size()), 64'd0);
    check("left_wb", 64'(exp_wb.size()), 64'd0);
    check("left_rd", 64'(exp_rd.size()), 64'd0);
    check("left_ov", 64'(exp_ov.size()), 64'd0);
  endtask

  // drivers
  task automatic do_reset();
    reset = 1'b0; start = 1'b0; ch_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge after the accepting edge (cycle 0).
  task automatic pulse_start();
    start = 1'b1; ch_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step_to(input int from, input int to);
    for (int n = from; n < to; n++) begin
      sample(n);
      @(negedge clk);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_inst"}, inst, INST_IDLE);
    check({tag, "_ctrl"}, {hold_cq, mac_deliver, core_clr, ch_req, out_valid, busy, done}, 7'd0);
    check({tag, "_ch_idx"}, ch_idx, 2'd0);
    check({tag, "_out_idx"}, out_idx, 3'd0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  initial begin
    int dn;

    // reset state
    reset = 1'b0; start = 1'b0; ch_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    do_reset();

    // single layer, ch_ready tied high (also start+ch_ready together)
    clear_tally();
    pulse_start();
    check("c0_state", dbg_state, S_WAIT_CH);
    check("c0_req", {ch_req, busy, hold_cq}, 3'b111);
    check("c0_ch_idx", ch_idx, 2'd0);
    check("c0_inst", inst, INST_IDLE);
    run_to_done(0, dn);
    verify_layer(dn, 299);
    @(negedge clk);
    check("after_done_state", dbg_state, S_IDLE);
    check("after_done_busy", busy, 1'b0);

    // handshake stall at channel 1
    do_reset();
    clear_tally();
    pulse_start();
    step_to(0, 80);
    ch_ready = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      if (k != 0) @(negedge clk);
      sample(80 + k);
      check("stall_req", {ch_req, ch_idx}, 3'b101);
      check("stall_inst", inst, INST_IDLE);
    end
    ch_ready = 1'b1;
    @(negedge clk);
    sample(131);
    check("resume_l0", {inst[B_L0_WR], inst[B_A_XMEM +: 11]}, {1'b1, 11'h400});
    @(negedge clk);
    run_to_done(132, dn);
    verify_layer(dn, 349);

    // reset during EXEC of channel 2
    do_reset();
    clear_tally();
    pulse_start();
    step_to(0, 202);
    check("pre_rst_exec", {ch_idx, inst[B_EXECUTE]}, 3'b101);
    #2 reset = 1'b0;
    #1 check_idle_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");
    clear_tally();
    pulse_start();
    check("replay_ch_idx", {ch_req, ch_idx}, 3'b100);
    run_to_done(0, dn);
    verify_layer(dn, 299);

    // start pulsed during DRAIN is ignored
    do_reset();
    clear_tally();
    pulse_start();
    step_to(0, 60);
    check("drain_state", dbg_state, S_DRAIN);
    start = 1'b1;
    sample(60);
    @(negedge clk);
    start = 1'b0;
    check("drain_kept", dbg_state, S_DRAIN);
    run_to_done(61, dn);
    verify_layer(dn, 299);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
